// File: rtl/sifive_reset_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Lock-loss monitoring is enabled with SIFIVE_RESET_LOCK_MONITOR_EN.
package sifive_reset_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_DEBOUNCE,
        ST_RELEASE,
        ST_RUN,
        ST_SWRST
    } state_t;

    localparam int DEF_NUM_OUT       = 4;
    localparam int DEF_DEBOUNCE_BITS = 8;
    localparam int DEF_STAGE_GAP     = 16;
    localparam int DEF_SYNC_DEPTH    = 4;
    localparam int DEF_SW_HOLD       = 32;

    function automatic int safe_clog2(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sifive_reset_sync_n.sv
// Async-assert, sync-deassert flop chain; also used as a plain
// multi-flop synchroniser for level inputs.
module sifive_reset_sync_n #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic areset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/sifive_reset_sequencer.sv
// Lock-gated staged reset sequencer with software re-reset handshake.
// Define SIFIVE_RESET_LOCK_MONITOR_EN to re-enter HOLD on lock loss.
module sifive_reset_sequencer
    import sifive_reset_pkg::*;
#(
    parameter int NUM_OUT       = DEF_NUM_OUT,
    parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
    parameter int STAGE_GAP     = DEF_STAGE_GAP,
    parameter int SYNC_DEPTH    = DEF_SYNC_DEPTH,
    parameter int SW_HOLD       = DEF_SW_HOLD
) (
    input  logic               clock,
    input  logic               areset_n,
    input  logic               locked,
    input  logic               sw_req,
    output logic               sw_ack,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               done
);

    localparam int DW = DEBOUNCE_BITS + 1;
    localparam int CW = safe_clog2(max2(STAGE_GAP, SW_HOLD) + 1);
    localparam int SW = safe_clog2(NUM_OUT);

    localparam logic [DW-1:0] DEB_MAX =
        DW'((64'd1 << DEBOUNCE_BITS) - 64'd1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(SW_HOLD - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_OUT - 1);

    localparam logic [NUM_OUT-1:0] ALL = {NUM_OUT{1'b1}};
    localparam logic [NUM_OUT-1:0] ONE = NUM_OUT'(1);

    logic          rst_sync_n;
    logic          locked_s;
    logic          lock_lost;
    state_t        state;
    logic [DW-1:0] deb_cnt;
    logic [CW-1:0] gap_cnt;
    logic [CW-1:0] hold_cnt;
    logic [SW-1:0] stage;
    logic [SW-1:0] stage_nxt;

    sifive_reset_sync_n #(
        .DEPTH    (SYNC_DEPTH)
    ) u_rst_sync (
        .clock    (clock),
        .areset_n (areset_n),
        .d        (1'b1),
        .q        (rst_sync_n)
    );

    sifive_reset_sync_n #(
        .DEPTH    (2)
    ) u_lock_sync (
        .clock    (clock),
        .areset_n (areset_n),
        .d        (locked),
        .q        (locked_s)
    );

    assign stage_nxt = stage + SW'(1);

`ifdef SIFIVE_RESET_LOCK_MONITOR_EN
    assign lock_lost = !locked_s &&
        (state inside {ST_RELEASE, ST_RUN, ST_SWRST});
`else
    assign lock_lost = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ST_HOLD;
            deb_cnt   <= '0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
            stage     <= '0;
            reset_out <= ALL;
            sw_ack    <= 1'b0;
            done      <= 1'b0;
        end else if (lock_lost) begin
            state     <= ST_HOLD;
            deb_cnt   <= '0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
            stage     <= '0;
            reset_out <= ALL;
            sw_ack    <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_HOLD: begin
                    reset_out <= ALL;
                    deb_cnt   <= '0;
                    if (locked_s) begin
                        // the qualifying edge counts as the first stable cycle
                        state   <= ST_DEBOUNCE;
                        deb_cnt <= DW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!locked_s) begin
                        state   <= ST_HOLD;
                        deb_cnt <= '0;
                    end else if (deb_cnt >= DEB_MAX) begin
                        state     <= ST_RELEASE;
                        deb_cnt   <= '0;
                        gap_cnt   <= '0;
                        stage     <= '0;
                        reset_out <= ALL & ~ONE;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (stage == STAGE_LAST) begin
                        state   <= ST_RUN;
                        gap_cnt <= '0;
                        done    <= 1'b1;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        stage     <= stage_nxt;
                        reset_out <= reset_out & ~(ONE << stage_nxt);
                    end else begin
                        gap_cnt <= gap_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_req) begin
                        state     <= ST_SWRST;
                        hold_cnt  <= '0;
                        stage     <= '0;
                        reset_out <= ALL;
                        done      <= 1'b0;
                    end
                end
                ST_SWRST: begin
                    if (!sw_ack) begin
                        if (hold_cnt == HOLD_LAST) begin
                            sw_ack <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + CW'(1);
                        end
                    end else if (!sw_req) begin
                        // debounce is skipped: lock was already qualified
                        state     <= ST_RELEASE;
                        sw_ack    <= 1'b0;
                        hold_cnt  <= '0;
                        gap_cnt   <= '0;
                        stage     <= '0;
                        reset_out <= ALL & ~ONE;
                    end
                end
                default: begin
                    state     <= ST_HOLD;
                    reset_out <= ALL;
                    sw_ack    <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sifive_reset_sequencer.md
# sifive_reset_sequencer

Single-clock, parametrised reset sequencer that drives `NUM_OUT` active-high reset outputs and releases them in a fixed order with programmable spacing. It is gated by a synchronised PLL-lock input with debounce, and supports a software-requested re-reset over a 4-phase handshake. It sits after the board reset/lock logic. Downstream domain-crossing synchronisers consume its outputs.

## Interface
Parameters:
- `NUM_OUT`, 4: number of reset outputs; legal range 1..16.
- `DEBOUNCE_BITS`, 8: lock must be stable for 2^`DEBOUNCE_BITS` cycles.
- `STAGE_GAP`, 16: cycles between consecutive output releases; must be at least 1.
- `SYNC_DEPTH`, 4: depth of the `areset_n` deassertion synchroniser; must be at least 2.
- `SW_HOLD`, 32: minimum cycles that outputs are held during a software reset; must be at least 1.

Ports:
- `clock`, in, 1: sole clock.
- `areset_n`, in, 1: asynchronous, active-low reset. Assertion takes effect asynchronously. Deassertion is synchronised internally.
- `locked`, in, 1: PLL lock, asynchronous to `clock`; synchronised internally with 2 flops.
- `sw_req`, in, 1: software reset request, synchronous to `clock`; level, 4-phase.
- `sw_ack`, out, 1: software reset acknowledge.
- `reset_out`, out, `NUM_OUT`: active-high resets. Bit 0 is released first.
- `done`, out, 1: high when all outputs are released and the FSM is in RUN.

## Operation
- Internal reset `rst_i` is asserted asynchronously by `areset_n`=0 and deasserted `SYNC_DEPTH` edges after `areset_n` rises.
- While `rst_i` is high:
  - `reset_out` is all ones.
  - `sw_ack`=0 and `done`=0.
  - State is HOLD and all counters are 0.
- States:
  - HOLD: all outputs are asserted. Go to DEBOUNCE when `locked_s`=1.
  - DEBOUNCE: count cycles while `locked_s`=1. If `locked_s`=0, return to HOLD with the count cleared. When the count reaches 2^`DEBOUNCE_BITS`-1, go to RELEASE with stage=0.
  - RELEASE:
    - Clear `reset_out[stage]` on the entry edge.
    - The gap counter counts `STAGE_GAP` cycles, then stage increments and the next bit clears.
    - After bit `NUM_OUT`-1 clears, go to RUN.
  - RUN: `done`=1. If `sw_req`=1, go to SWRST.
  - SWRST:
    - Set all outputs on the entry edge and hold them for `SW_HOLD` cycles.
    - Then `sw_ack`=1 and wait for `sw_req`=0.
    - Then `sw_ack`=0 and go to RELEASE with stage=0. DEBOUNCE is skipped.
- `sw_req` is ignored outside RUN and stays pending. `sw_ack` stays 0 until the request is serviced.
- If `sw_req` drops before `sw_ack` rises, the hold still completes, `sw_ack` pulses for one cycle, and then RELEASE follows.
- Outputs are released in order but asserted together, always in the same cycle.
- Counter widths:
  - Debounce counter: `DEBOUNCE_BITS`+1 bits.
  - Gap and hold counters: clog2(max(`STAGE_GAP`, `SW_HOLD`)+1) bits.
  - Stage index: clog2(`NUM_OUT`) bits, minimum 1.
  - No counter wraps; each saturates or clears on a state change.

## Timing
- All outputs are registered and are 1 (`reset_out`) or 0 (`sw_ack`, `done`) at reset.
- Let T0 be the first edge in HOLD with `locked_s`=1:
  - DEBOUNCE is entered at T0+1.
  - `reset_out[0]` falls at T0+2^`DEBOUNCE_BITS`.
  - `reset_out[i]` falls at T0+2^`DEBOUNCE_BITS`+i·`STAGE_GAP`.
  - `done` rises on the edge after the last bit falls.
- `sw_req` sampled high in RUN at edge E:
  - All outputs rise and `done` falls at E+1.
  - `sw_ack` rises at E+1+`SW_HOLD`.
- `sw_req` sampled low at edge F while `sw_ack`=1: `sw_ack` falls and `reset_out[0]` falls at F+1.
- The latency from `locked` to `locked_s` is 2 cycles.

## Configuration
- `SIFIVE_RESET_LOCK_MONITOR_EN` defined:
  - In RELEASE, RUN or SWRST, `locked_s`=0 sets all outputs on the next edge, clears `sw_ack` and `done`, and enters HOLD.
  - Lock loss has priority over a simultaneous `sw_req`.
- Not defined: `locked_s` is observed only in HOLD and DEBOUNCE, and lock loss afterwards has no effect.

## Structure
- Package `sifive_reset_pkg` contains:
  - The state enum: HOLD, DEBOUNCE, RELEASE, RUN, SWRST.
  - Default parameter constants.
  - A clog2-safe width helper.
- Sub-module `sifive_reset_sync_n` (parameter `DEPTH`) provides asynchronous-assert, synchronous-deassert synchronisation of `areset_n`. It also serves as the 2-flop `locked` synchroniser.

## Test plan
Each bench uses `NUM_OUT`=4, `DEBOUNCE_BITS`=3, `STAGE_GAP`=5, `SW_HOLD`=4, `SYNC_DEPTH`=4.
- Power-up: `locked`=1 and `areset_n` rises. `reset_out` walks 1111→1110→1100→1000→0000 at 5-cycle spacing; `done` rises one cycle after the final release.
- Lock glitch in DEBOUNCE: `locked` is low for 1 cycle at count 5. The FSM returns to HOLD and the full 8-cycle debounce restarts; no output is released early.
- Software reset in RUN: `sw_req`=1. All outputs are 1 next cycle, `sw_ack` rises 4 cycles later; dropping `sw_req` gives `sw_ack`=0 and a staged release without debounce.
- Mid-RELEASE `areset_n` pulse after bit 1 is released: all outputs return to 1 asynchronously and the sequence restarts from HOLD.
- With `SIFIVE_RESET_LOCK_MONITOR_EN`, `locked` falls in RUN: 3 cycles later (2 sync + 1), all outputs are 1 and `done`=0. Without the macro, the outputs stay at 0000.
- Early `sw_req` in DEBOUNCE: there is no effect until RUN, then SWRST entry occurs on the next cycle.
